regbus_cmd_initiator: RTL and testbench

REGBUS_CMD_INITIATOR -- requirements
Module: regbus_cmd_initiator

---
 rtl/regbus_cmd_initiator.sv | 185 ++++++++++++++++++
 tb/tb_regbus_cmd_initiator.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbus_cmd_initiator.sv
// Register-bus command initiator: accepts one command, drives it onto the
// register bus until ready or timeout, then holds the result until consumed.

package regbus_cmd_initiator_pkg;

  typedef struct packed {
    logic [47:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_a48_d32_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_a48_d32_rsp_t;

endpackage

module regbus_cmd_initiator
  import regbus_cmd_initiator_pkg::*;
#(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024,
  parameter type         req_t         = reg_a48_d32_req_t,
  parameter type         rsp_t         = reg_a48_d32_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic                   cmd_write_i,
  input  logic [DataWidth-1:0]   cmd_wdata_i,
  input  logic [DataWidth/8-1:0] cmd_wstrb_i,
  output req_t                   reg_req_o,
  input  rsp_t                   reg_rsp_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic                   rsp_timeout_o,
  output logic [31:0]            done_cnt_o
);

  localparam int unsigned StrbWidth   = DataWidth / 8;
  localparam int unsigned CntWidth    = ($clog2(TimeoutCycles + 1) > 1) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int unsigned TimeoutLast = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
  localparam bit          TimeoutEn   = (TimeoutCycles > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   write_q, write_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [StrbWidth-1:0]   wstrb_q, wstrb_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   error_q, error_d;
  logic                   timeout_q, timeout_d;
  logic [31:0]            done_cnt_q, done_cnt_d;
  logic                   timeout_hit;

  // Last allowed wait cycle reached with no ready; ready on this cycle wins.
  assign timeout_hit = TimeoutEn && (cnt_q == CntWidth'(TimeoutLast)) && !reg_rsp_i.ready;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid_i) state_d = BUSY;
      BUSY:    if (reg_rsp_i.ready || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; the bus request is only driven while BUSY.
  always_comb begin
    cmd_ready_o     = 1'b0;
    rsp_valid_o     = 1'b0;
    reg_req_o       = '0;
    case (state_q)
      IDLE: cmd_ready_o = 1'b1;
      BUSY: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.addr  = addr_q;
        reg_req_o.write = write_q;
        reg_req_o.wdata = wdata_q;
        reg_req_o.wstrb = wstrb_q;
      end
      RESP:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Command capture, wait counter, result capture and completion count.
  always_comb begin
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    timeout_d  = timeout_q;
    done_cnt_d = done_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          write_d = cmd_write_i;
          wdata_d = cmd_wdata_i;
          wstrb_d = cmd_wstrb_i;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (reg_rsp_i.ready) begin
          rdata_d   = write_q ? '0 : DataWidth'(reg_rsp_i.rdata);
          error_d   = reg_rsp_i.error;
          timeout_d = 1'b0;
        end else if (timeout_hit) begin
          rdata_d   = '0;
          error_d   = 1'b1;
          timeout_d = 1'b1;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) done_cnt_d = done_cnt_q + 32'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
      timeout_q  <= timeout_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign rsp_rdata_o   = rdata_q;
  assign rsp_error_o   = error_q;
  assign rsp_timeout_o = timeout_q;
  assign done_cnt_o    = done_cnt_q;

endmodule

// File: tb/tb_regbus_cmd_initiator.sv
// Scoreboard bench for regbus_cmd_initiator: driver, bus responder and
// response monitor run as independent processes around a transaction model.

module tb_regbus_cmd_initiator;
  import regbus_cmd_initiator_pkg::*;

  localparam int unsigned TIMEOUT = 8;

  logic             clk;
  logic             rst_ni;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [47:0]      cmd_addr_i;
  logic             cmd_write_i;
  logic [31:0]      cmd_wdata_i;
  logic [3:0]       cmd_wstrb_i;
  reg_a48_d32_req_t reg_req_o;
  reg_a48_d32_rsp_t reg_rsp_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_rdata_o;
  logic             rsp_error_o;
  logic             rsp_timeout_o;
  logic [31:0]      done_cnt_o;

  regbus_cmd_initiator #(
    .AddrWidth    (48),
    .DataWidth    (32),
    .TimeoutCycles(TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_write_i  (cmd_write_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .cmd_wstrb_i  (cmd_wstrb_i),
    .reg_req_o    (reg_req_o),
    .reg_rsp_i    (reg_rsp_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_error_o  (rsp_error_o),
    .rsp_timeout_o(rsp_timeout_o),
    .done_cnt_o   (done_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // What the responder must see and answer for one transaction.
  typedef struct {
    logic [47:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int unsigned wait_n;
    logic [31:0] rdata;
    logic        err;
    int unsigned busy_len;
  } plan_t;

  // What the requester must get back for one transaction.
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int unsigned lat;
    int unsigned t;
  } exp_t;

  plan_t       plan_q[$];
  exp_t        exp_q[$];
  logic [31:0] model_done = 32'd0;
  int          sink_mode  = 0;
  int          n_checks   = 0;
  int          n_err      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Transaction outcome from the bus rules: ready on wait cycle wn completes
  // normally if it arrives within the TIMEOUT allowed cycles, else abort.
  function automatic void model(input logic wr, input int unsigned wn, input logic [31:0] rd,
                                input logic er, output int unsigned busy_len, output exp_t e);
    bit ok;
    ok       = (TIMEOUT == 0) || (wn < TIMEOUT);
    busy_len = ok ? wn + 1 : TIMEOUT;
    e.rdata  = ok ? (wr ? 32'd0 : rd) : 32'd0;
    e.err    = ok ? er : 1'b1;
    e.to     = !ok;
    e.lat    = busy_len + 1;
    e.t      = 0;
  endfunction

  task automatic issue(input logic [47:0] a, input logic wr, input logic [31:0] wd,
                       input logic [3:0] ws, input int unsigned wn, input logic [31:0] rd,
                       input logic er);
    plan_t p;
    exp_t  e;
    int    guard;
    @(negedge clk);
    cmd_addr_i  = a;
    cmd_write_i = wr;
    cmd_wdata_i = wd;
    cmd_wstrb_i = ws;
    cmd_valid_i = 1'b1;
    guard = 0;
    while (!cmd_ready_o && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready_o) begin
      chk("cmd_accept_wait", 64'(cmd_ready_o), 64'd1);
      cmd_valid_i = 1'b0;
      return;
    end
    p.addr = a; p.write = wr; p.wdata = wd; p.wstrb = ws;
    p.wait_n = wn; p.rdata = rd; p.err = er;
    model(wr, wn, rd, er, p.busy_len, e);
    e.t = cyc;
    plan_q.push_back(p);
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    cmd_addr_i  = 48'($urandom) ^ {16'($urandom), 32'd0};
    cmd_write_i = 1'($urandom);
    cmd_wdata_i = $urandom;
    cmd_wstrb_i = 4'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("done_cnt_idle", 64'(done_cnt_o), 64'(model_done));
    chk("cmd_ready_idle", 64'(cmd_ready_o), 64'd1);
  endtask

  // Bus responder: answers each request after its planned wait cycles and
  // checks the request is correct, stable, and idle-zero outside BUSY.
  initial begin
    plan_t       cur;
    bit          in_txn;
    int unsigned k;
    in_txn    = 0;
    k         = 0;
    reg_rsp_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        in_txn    = 0;
        reg_rsp_i = '0;
      end else if (reg_req_o.valid) begin
        if (!in_txn) begin
          if (plan_q.size() == 0) begin
            chk("unexpected_request", 64'd1, 64'd0);
            cur.addr = reg_req_o.addr; cur.write = reg_req_o.write;
            cur.wdata = reg_req_o.wdata; cur.wstrb = reg_req_o.wstrb;
            cur.wait_n = 0; cur.rdata = 32'd0; cur.err = 1'b0; cur.busy_len = 1;
          end else begin
            cur = plan_q.pop_front();
          end
          in_txn = 1;
          k      = 0;
        end else begin
          k++;
        end
        chk("req_addr", 64'(reg_req_o.addr), 64'(cur.addr));
        chk("req_write", 64'(reg_req_o.write), 64'(cur.write));
        chk("req_wdata", 64'(reg_req_o.wdata), 64'(cur.wdata));
        chk("req_wstrb", 64'(reg_req_o.wstrb), 64'(cur.wstrb));
        reg_rsp_i.ready = (k == cur.wait_n);
        reg_rsp_i.rdata = reg_rsp_i.ready ? cur.rdata : $urandom;
        reg_rsp_i.error = reg_rsp_i.ready ? cur.err : 1'($urandom);
      end else begin
        if (in_txn) begin
          chk("req_valid_cycles", 64'(k + 1), 64'(cur.busy_len));
          in_txn = 0;
        end
        chk("req_idle_zero", 64'(reg_req_o != '0), 64'd0);
        reg_rsp_i.ready = 1'($urandom);
        reg_rsp_i.rdata = $urandom;
        reg_rsp_i.error = 1'($urandom);
      end
    end
  end

  // Response monitor: compares every presented response cycle against the
  // head of the scoreboard and applies the selected backpressure pattern.
  initial begin
    bit          first;
    int unsigned hold;
    bit          rr;
    exp_t        e;
    first       = 1;
    hold        = 0;
    rsp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        rsp_ready_i = 1'b0;
        first       = 1;
        hold        = 0;
      end else if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_response", 64'd1, 64'd0);
          rsp_ready_i = 1'b1;
        end else begin
          e = exp_q[0];
          if (first) begin
            chk("rsp_latency", 64'(cyc - e.t), 64'(e.lat));
            chk("done_cnt_before", 64'(done_cnt_o), 64'(model_done));
          end
          chk("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
          chk("rsp_error", 64'(rsp_error_o), 64'(e.err));
          chk("rsp_timeout", 64'(rsp_timeout_o), 64'(e.to));
          chk("cmd_ready_in_resp", 64'(cmd_ready_o), 64'd0);
          first = 0;
          hold++;
          case (sink_mode)
            1:       rr = 1'b1;
            2:       rr = (hold > 10);
            default: rr = ($urandom_range(0, 2) != 0);
          endcase
          rsp_ready_i = rr;
          if (rr) begin
            void'(exp_q.pop_front());
            model_done = model_done + 32'd1;
            first      = 1;
            hold       = 0;
          end
        end
      end else begin
        rsp_ready_i = 1'($urandom);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "watchdog");
  end

  // Stimulus sequence.
  initial begin
    int guard;
    rst_ni      = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_write_i = 1'b0;
    cmd_wdata_i = '0;
    cmd_wstrb_i = '0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("rst_req_zero", 64'(reg_req_o != '0), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata_o), 64'd0);
    chk("rst_error", 64'(rsp_error_o), 64'd0);
    chk("rst_timeout", 64'(rsp_timeout_o), 64'd0);
    chk("rst_done_cnt", 64'(done_cnt_o), 64'd0);

    // Directed: read, write with 5 waits, bus error, timeout.
    sink_mode = 1;
    issue(48'h1000, 1'b0, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);
    drain();
    issue(48'h2000, 1'b1, 32'hA5A5A5A5, 4'hF, 5, 32'h12345678, 1'b0);
    drain();
    issue(48'h3004, 1'b0, 32'h0, 4'h0, 2, 32'hCAFEF00D, 1'b1);
    drain();
    issue(48'h4008, 1'b0, 32'h0, 4'h0, 1000, 32'h0, 1'b0);
    drain();
    // Ready arriving exactly on the timeout cycle, and one cycle too late.
    issue(48'h500C, 1'b0, 32'h0, 4'h0, TIMEOUT - 1, 32'h0BADC0DE, 1'b0);
    issue(48'h6010, 1'b0, 32'h0, 4'h0, TIMEOUT, 32'h11111111, 1'b0);
    drain();

    // Backpressure with a second command waiting behind it.
    sink_mode = 2;
    issue(48'h7000, 1'b0, 32'h0, 4'h0, 1, 32'h55AA55AA, 1'b0);
    issue(48'h7004, 1'b1, 32'h01020304, 4'h3, 0, 32'hFFFFFFFF, 1'b1);
    drain();

    // Completion counter wrap.
    sink_mode = 1;
    force dut.done_cnt_q = 32'hFFFF_FFFF;
    model_done = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.done_cnt_q;
    @(negedge clk);
    chk("done_cnt_preset", 64'(done_cnt_o), 64'hFFFF_FFFF);
    issue(48'h8000, 1'b0, 32'h0, 4'h0, 0, 32'h0000BEEF, 1'b0);
    drain();

    // Randomized traffic with random backpressure and gaps.
    sink_mode = 0;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue({16'($urandom), 32'($urandom)}, 1'($urandom), $urandom, 4'($urandom),
            $urandom_range(0, 10), $urandom, 1'($urandom_range(0, 3) == 0));
    end
    drain();

    // Reset in the middle of a bus request.
    issue(48'h9000, 1'b0, 32'h0, 4'h0, 1000, 32'h0, 1'b0);
    guard = 0;
    while (!reg_req_o.valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("busy_before_reset", 64'(reg_req_o.valid), 64'd1);
    #1 rst_ni = 1'b0;
    #1;
    chk("reset_async_valid_drop", 64'(reg_req_o.valid), 64'd0);
    chk("reset_async_rsp_valid", 64'(rsp_valid_o), 64'd0);
    exp_q.delete();
    plan_q.delete();
    model_done = 32'd0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("post_reset_done_cnt", 64'(done_cnt_o), 64'd0);
    chk("post_reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    issue(48'hA000, 1'b0, 32'h0, 4'h0, 3, 32'h76543210, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
